// File: rtl/pc_trace_buffer_if.sv
// Bundle of capture, watchpoint and readback signals between a CPU/debug host and the trace buffer.
// Latency: none, wiring only.
// Backpressure: none; capture is fire-and-forget and reads are single-cycle requests.
// Ports (master = host side drives, slave = trace buffer):
//   fetch/pc/halt/clear/watch_en/watch_pc/rd_en/rd_idx : host -> buffer
//   rd_data/rd_valid/count/wrapped/stopped/watch_hit/fetch_total : buffer -> host
interface pc_trace_buffer_if #(
    parameter int PC_W  = 9,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic            fetch;
    logic [PC_W-1:0] pc;
    logic            halt;
    logic            clear;
    logic            watch_en;
    logic [PC_W-1:0] watch_pc;
    logic            rd_en;
    logic [AW-1:0]   rd_idx;
    logic [PC_W-1:0] rd_data;
    logic            rd_valid;
    logic [AW:0]     count;
    logic            wrapped;
    logic            stopped;
    logic            watch_hit;
    logic [15:0]     fetch_total;

    modport master (
        output fetch, pc, halt, clear, watch_en, watch_pc, rd_en, rd_idx,
        input  rd_data, rd_valid, count, wrapped, stopped, watch_hit, fetch_total
    );

    modport slave (
        input  fetch, pc, halt, clear, watch_en, watch_pc, rd_en, rd_idx,
        output rd_data, rd_valid, count, wrapped, stopped, watch_hit, fetch_total
    );
endinterface

// File: rtl/pc_trace_buffer.sv
// Records the PC of every CPU fetch into a DEPTH-entry trace, circular (MODE 0) or one-shot (MODE 1).
// Latency: capture takes effect on the fetch edge; reads return one cycle after rd_en.
// Backpressure: none; fetches arriving while frozen are dropped, reads are always accepted.
// Ports: clk (sole clock), reset_n (async active-low), bus (pc_trace_buffer_if.slave) carrying
//        capture inputs, watchpoint, read request/response and status counters.
module pc_trace_buffer #(
    parameter int PC_W  = 9,
    parameter int DEPTH = 16,
    parameter int MODE  = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    pc_trace_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam bit ONE_SHOT = (MODE == 1);

    typedef enum logic {RUN = 1'b0, STOP = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wp_q, wp_d;
    logic [AW:0]     count_q, count_d;
    logic            wrapped_q, wrapped_d;
    logic            watch_hit_q, watch_hit_d;
    logic [15:0]     fetch_total_q, fetch_total_d;
    logic            rd_valid_q, rd_valid_d;
    logic [PC_W-1:0] rd_data_q, rd_data_d;

    logic [PC_W-1:0] mem [DEPTH];
    logic            wr_en;
    logic            full;
    logic [AW-1:0]   rd_addr;

    assign full = (count_q == FULL);

    // Capture FSM and status counters.
    always_comb begin
        state_d       = state_q;
        wp_d          = wp_q;
        count_d       = count_q;
        wrapped_d     = wrapped_q;
        watch_hit_d   = watch_hit_q;
        fetch_total_d = fetch_total_q;
        wr_en         = 1'b0;

        if (bus.clear) begin
            // clear beats both a same-cycle fetch and halt
            state_d       = RUN;
            wp_d          = '0;
            count_d       = '0;
            wrapped_d     = 1'b0;
            watch_hit_d   = 1'b0;
            fetch_total_d = '0;
        end else if (state_q == RUN) begin
            // one-shot never writes past full; it should already be in STOP then
            if (bus.fetch && !(ONE_SHOT && full)) begin
                wr_en = 1'b1;
                wp_d  = wp_q + 1'b1;
                if (!full) begin
                    count_d = count_q + 1'b1;
                end else begin
                    wrapped_d = 1'b1;
                end
                if (fetch_total_q != 16'hFFFF) begin
                    fetch_total_d = fetch_total_q + 16'd1;
                end
                if (bus.watch_en && (bus.pc == bus.watch_pc)) begin
                    watch_hit_d = 1'b1;
                end
                // freeze as soon as the last free slot is consumed
                if (ONE_SHOT && (count_q == FULL - 1'b1)) begin
                    state_d = STOP;
                end
            end
            // a fetch in the halt cycle is still recorded above
            if (bus.halt) begin
                state_d = STOP;
            end
        end
    end

    // Logical index 0 is the oldest entry; once full, the oldest sits at wp.
    assign rd_addr = full ? (wp_q + bus.rd_idx) : bus.rd_idx;

    // Reads use pre-write state, so a same-cycle fetch is not visible.
    always_comb begin
        rd_valid_d = bus.rd_en && ({1'b0, bus.rd_idx} < count_q);
        rd_data_d  = rd_valid_d ? mem[rd_addr] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            wp_q          <= '0;
            count_q       <= '0;
            wrapped_q     <= 1'b0;
            watch_hit_q   <= 1'b0;
            fetch_total_q <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            wp_q          <= wp_d;
            count_q       <= count_d;
            wrapped_q     <= wrapped_d;
            watch_hit_q   <= watch_hit_d;
            fetch_total_q <= fetch_total_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Storage is not reset; entries beyond count are never reported valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp_q] <= bus.pc;
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.count       = count_q;
    assign bus.wrapped     = wrapped_q;
    assign bus.stopped     = (state_q == STOP);
    assign bus.watch_hit   = watch_hit_q;
    assign bus.fetch_total = fetch_total_q;
endmodule

// File: tb/tb_pc_trace_buffer.sv
// Drives a circular (MODE 0) and a one-shot (MODE 1) trace buffer with the same stimulus and
// compares both against a shift-register reference model; read results go through a scoreboard.
module tb_pc_trace_buffer;
    localparam int PC_W  = 9;
    localparam int DEPTH = 4;

    logic            clk;
    logic            reset_n;
    logic            fetch;
    logic [PC_W-1:0] pc;
    logic            halt;
    logic            clear;
    logic            watch_en;
    logic [PC_W-1:0] watch_pc;
    logic            rd_en;
    logic [1:0]      rd_idx;

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pc_trace_buffer_if #(.PC_W(PC_W), .DEPTH(DEPTH)) if0 ();
    pc_trace_buffer_if #(.PC_W(PC_W), .DEPTH(DEPTH)) if1 ();

    assign if0.fetch    = fetch;
    assign if0.pc       = pc;
    assign if0.halt     = halt;
    assign if0.clear    = clear;
    assign if0.watch_en = watch_en;
    assign if0.watch_pc = watch_pc;
    assign if0.rd_en    = rd_en;
    assign if0.rd_idx   = rd_idx;
    assign if1.fetch    = fetch;
    assign if1.pc       = pc;
    assign if1.halt     = halt;
    assign if1.clear    = clear;
    assign if1.watch_en = watch_en;
    assign if1.watch_pc = watch_pc;
    assign if1.rd_en    = rd_en;
    assign if1.rd_idx   = rd_idx;

    pc_trace_buffer #(.PC_W(PC_W), .DEPTH(DEPTH), .MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0.slave)
    );
    pc_trace_buffer #(.PC_W(PC_W), .DEPTH(DEPTH), .MODE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1.slave)
    );

    // Reference model, index 0 = MODE 0, index 1 = MODE 1; mdat[m][0] is always the oldest entry.
    int              mcnt   [2];
    logic [PC_W-1:0] mdat   [2][DEPTH];
    bit              mstop  [2];
    bit              mwrap  [2];
    bit              mhit   [2];
    int              mtotal [2];

    typedef struct {
        int              m;
        logic            v;
        logic [PC_W-1:0] d;
    } sb_t;
    sb_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mcnt[m] = 0; mstop[m] = 0; mwrap[m] = 0; mhit[m] = 0; mtotal[m] = 0;
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_cnt0"},   32'(if0.count),       32'(mcnt[0]));
        check_eq({tag, "_wrap0"},  32'(if0.wrapped),     32'(mwrap[0]));
        check_eq({tag, "_stop0"},  32'(if0.stopped),     32'(mstop[0]));
        check_eq({tag, "_hit0"},   32'(if0.watch_hit),   32'(mhit[0]));
        check_eq({tag, "_tot0"},   32'(if0.fetch_total), 32'(mtotal[0]));
        check_eq({tag, "_cnt1"},   32'(if1.count),       32'(mcnt[1]));
        check_eq({tag, "_wrap1"},  32'(if1.wrapped),     32'(mwrap[1]));
        check_eq({tag, "_stop1"},  32'(if1.stopped),     32'(mstop[1]));
        check_eq({tag, "_hit1"},   32'(if1.watch_hit),   32'(mhit[1]));
        check_eq({tag, "_tot1"},   32'(if1.fetch_total), 32'(mtotal[1]));
    endtask

    // One clock: scoreboard the read against pre-edge model state, advance the model,
    // then compare after the edge. Pulse inputs are dropped afterwards; levels persist.
    task automatic tick();
        sb_t e;
        bit  did_rd;
        did_rd = rd_en;
        for (int m = 0; m < 2; m++) begin
            if (rd_en) begin
                e.m = m;
                e.v = (int'(rd_idx) < mcnt[m]);
                e.d = e.v ? mdat[m][rd_idx] : '0;
                sb.push_back(e);
            end
            if (clear) begin
                mcnt[m] = 0; mstop[m] = 0; mwrap[m] = 0; mhit[m] = 0; mtotal[m] = 0;
            end else if (!mstop[m]) begin
                if (fetch) begin
                    if (mcnt[m] < DEPTH) begin
                        mdat[m][mcnt[m]] = pc;
                        mcnt[m]++;
                    end else begin
                        for (int k = 0; k < DEPTH - 1; k++) mdat[m][k] = mdat[m][k+1];
                        mdat[m][DEPTH-1] = pc;
                        mwrap[m] = 1;
                    end
                    if (mtotal[m] < 65535) mtotal[m]++;
                    if (watch_en && pc == watch_pc) mhit[m] = 1;
                    if (m == 1 && mcnt[m] == DEPTH) mstop[m] = 1;
                end
                if (halt) mstop[m] = 1;
            end
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq($sformatf("rd_valid_m%0d", e.m),
                     32'(e.m == 0 ? if0.rd_valid : if1.rd_valid), 32'(e.v));
            check_eq($sformatf("rd_data_m%0d", e.m),
                     32'(e.m == 0 ? if0.rd_data : if1.rd_data), 32'(e.d));
        end
        if (!did_rd) begin
            check_eq("rd_idle_v0", 32'(if0.rd_valid), 32'd0);
            check_eq("rd_idle_v1", 32'(if1.rd_valid), 32'd0);
        end
        fetch = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_fetch(input int p);
        fetch = 1'b1;
        pc    = PC_W'(p);
        tick();
    endtask

    task automatic do_read(input int idx);
        rd_en  = 1'b1;
        rd_idx = 2'(idx);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        reset_n = 1'b0; fetch = 1'b0; pc = '0; halt = 1'b0; clear = 1'b0;
        watch_en = 1'b0; watch_pc = '0; rd_en = 1'b0; rd_idx = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        check_eq("reset_rdv", 32'(if0.rd_valid), 32'd0);
        check_eq("reset_rdd", 32'(if0.rd_data), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Six fetches into a depth-4 buffer: circular keeps newest, one-shot keeps first.
        for (int i = 0; i < 6; i++) do_fetch(i);
        check_state("fill");
        check_eq("circ_cnt",   32'(if0.count),       32'd4);
        check_eq("circ_wrap",  32'(if0.wrapped),     32'd1);
        check_eq("circ_tot",   32'(if0.fetch_total), 32'd6);
        check_eq("one_stop",   32'(if1.stopped),     32'd1);
        check_eq("one_wrap",   32'(if1.wrapped),     32'd0);
        check_eq("one_tot",    32'(if1.fetch_total), 32'd4);
        for (int i = 0; i < 4; i++) begin
            do_read(i);
            check_eq("circ_rd", 32'(if0.rd_data), 32'(i + 2));
            check_eq("one_rd",  32'(if1.rd_data), 32'(i));
        end

        // Halt with a simultaneous fetch still records it; later fetches are ignored.
        clear = 1'b1;
        tick();
        check_state("clr1");
        halt = 1'b1;
        do_fetch(7);
        halt = 1'b0;
        do_fetch(8);
        check_state("halt");
        check_eq("halt_cnt",  32'(if0.count),       32'd1);
        check_eq("halt_stop", 32'(if0.stopped),     32'd1);
        check_eq("halt_tot",  32'(if0.fetch_total), 32'd1);
        do_read(0);
        check_eq("halt_rd",   32'(if0.rd_data), 32'd7);

        // Watchpoint, then clear racing a fetch.
        clear = 1'b1;
        tick();
        watch_en = 1'b1;
        watch_pc = 9'd3;
        do_fetch(1);
        check_eq("watch_pre", 32'(if0.watch_hit), 32'd0);
        do_fetch(3);
        check_eq("watch_set", 32'(if0.watch_hit), 32'd1);
        do_fetch(4);
        check_state("watch");
        clear = 1'b1;
        do_fetch(3);
        check_state("clrfetch");
        check_eq("clrf_cnt",  32'(if0.count),     32'd0);
        check_eq("clrf_hit",  32'(if0.watch_hit), 32'd0);
        check_eq("clrf_stop", 32'(if0.stopped),   32'd0);
        watch_en = 1'b0;

        // Out-of-range read, and read racing a write.
        do_fetch(10);
        do_fetch(11);
        do_read(3);
        check_eq("oor_v", 32'(if0.rd_valid), 32'd0);
        check_eq("oor_d", 32'(if0.rd_data),  32'd0);
        rd_en  = 1'b1;
        rd_idx = 2'd1;
        do_fetch(20);
        check_eq("rbw_d",   32'(if0.rd_data), 32'd11);
        check_eq("rbw_cnt", 32'(if0.count),   32'd3);
        check_state("rbw");

        // Async reset between edges, mid-capture and with a read outstanding.
        do_fetch(5);
        do_read(1);
        rd_en  = 1'b1;
        rd_idx = 2'd0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_state("arst");
        check_eq("arst_rdv", 32'(if0.rd_valid), 32'd0);
        check_eq("arst_rdd", 32'(if0.rd_data),  32'd0);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rdv0", 32'(if0.rd_valid), 32'd0);
        check_eq("post_rdv1", 32'(if1.rd_valid), 32'd0);
        do_fetch(12);
        do_read(0);
        check_eq("post_rd0", 32'(if0.rd_data), 32'd12);
        check_eq("post_rd1", 32'(if1.rd_data), 32'd12);
        check_state("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
